// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the mem_ctrl_arb memory controller.
package mem_ctrl_pkg;

  // Per-channel request opcode; 2'b10 is reserved and behaves like idle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b11
  } op_e;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_READY   = 3'd1,
    ST_WFILL   = 3'd2,
    ST_HOSTWR  = 3'd3,
    ST_HOSTRD  = 3'd4,
    ST_RDRAIN  = 3'd5
  } state_e;

  // Number of words in one cache line.
  function automatic int fill_count(input int cl_width, input int word_width);
    return cl_width / word_width;
  endfunction

  // Bits needed to index a word within a line.
  function automatic int fill_bits(input int cl_width, input int word_width);
    return $clog2(fill_count(cl_width, word_width));
  endfunction

  // Bits needed to index a byte within a word.
  function automatic int byte_bits(input int word_width);
    return $clog2(word_width / 8);
  endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr,
// wrapping. The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      logic hit_s;
      int   ch_s;
      ch_s     = (int'(ptr) + off) % NUM_CH;
      hit_s    = req[ch_s] & ~found;
      gnt[ch_s] = gnt[ch_s] | hit_s;
      idx      = hit_s ? IDX_W'(ch_s) : idx;
      found    = found | hit_s;
    end
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Round-robin memory controller: arbitrates NUM_CH channels onto one host
// cache-line port, filling a line for writes and draining a line for reads.
// Optional feature macro: MEM_CTRL_CRIT_WORD_FIRST_EN (read drain starts at
// the requested word instead of word 0).
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64,
  parameter int NUM_CH        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_init,
  input  logic                          host_rd_ready,
  input  logic                          host_wr_ready,
  input  logic [CL_SIZE_WIDTH-1:0]      host_data_bus_read_in,
  output logic [CL_SIZE_WIDTH-1:0]      host_data_bus_write_out,
  output logic [ADDR_BITCOUNT-1:0]      host_addr,
  output logic                          host_re,
  output logic                          host_we,
  output logic                          host_rgo,
  output logic                          host_wgo,
  input  logic [ADDR_BITCOUNT-1:0]      address_offset,
  input  logic [2*NUM_CH-1:0]           req_op,
  input  logic [ADDR_BITCOUNT*NUM_CH-1:0] req_addr,
  input  logic [WORD_SIZE*NUM_CH-1:0]   req_wdata,
  output logic [NUM_CH-1:0]             grant,
  output logic [WORD_SIZE-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [NUM_CH-1:0]             tx_done,
  output logic                          ready
);

  localparam int FILL_COUNT = fill_count(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int FILL_BITS  = fill_bits(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int BYTE_BITS  = byte_bits(WORD_SIZE);
  localparam int LOW_BITS   = FILL_BITS + BYTE_BITS;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam logic [FILL_BITS-1:0] LAST_CNT = FILL_BITS'(FILL_COUNT - 1);
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_BITCOUNT-1:0] LINE_MASK =
    {{(ADDR_BITCOUNT-LOW_BITS){1'b1}}, {LOW_BITS{1'b0}}};

  state_e                     state_r;
  logic [NUM_CH-1:0]          grant_r;
  logic [CH_W-1:0]            gidx_r;
  logic [CH_W-1:0]            ptr_r;
  logic                       is_wr_r;
  logic [ADDR_BITCOUNT-1:0]   host_addr_r;
  logic [CL_SIZE_WIDTH-1:0]   line_r;
  logic [FILL_BITS-1:0]       cnt_r;

  logic [NUM_CH-1:0]          req_valid_s;
  logic [NUM_CH-1:0]          arb_gnt_s;
  logic [CH_W-1:0]            arb_idx_s;
  logic                       arb_found_s;
  logic [1:0]                 sel_op_s;
  logic [ADDR_BITCOUNT-1:0]   sel_addr_s;
  logic [WORD_SIZE-1:0]       sel_wdata_s;
  logic [FILL_BITS-1:0]       start_s;
  logic [FILL_BITS-1:0]       idx_s;
  logic [CH_W-1:0]            next_ptr_s;
  logic                       done_s;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_rr_arbiter (
    .req   (req_valid_s),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .found (arb_found_s)
  );

  // Decode eligible channels and select the candidate/granted channel fields.
  always_comb begin
    req_valid_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_valid_s[i] = (req_op[2*i +: 2] == OP_READ) || (req_op[2*i +: 2] == OP_WRITE);
    end
    sel_op_s    = req_op[2*int'(arb_idx_s) +: 2];
    sel_addr_s  = req_addr[ADDR_BITCOUNT*int'(arb_idx_s) +: ADDR_BITCOUNT] + address_offset;
    sel_wdata_s = req_wdata[WORD_SIZE*int'(gidx_r) +: WORD_SIZE];
    idx_s       = cnt_r + start_s;
    next_ptr_s  = (gidx_r == LAST_CH) ? '0 : gidx_r + 1'b1;
  end

`ifdef MEM_CTRL_CRIT_WORD_FIRST_EN
  logic [FILL_BITS-1:0] start_r;

  // Capture the requested word index at grant so the drain begins there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= '0;
    end else if ((state_r == ST_READY) && arb_found_s) begin
      start_r <= sel_addr_s[LOW_BITS-1:BYTE_BITS];
    end
  end

  assign start_s = start_r;
`else
  assign start_s = '0;
`endif

  assign done_s = ((state_r == ST_HOSTWR) && host_wr_ready) ||
                  ((state_r == ST_RDRAIN) && (cnt_r == LAST_CNT));

  assign ready                   = (state_r != ST_STARTUP);
  assign host_wgo                = (state_r == ST_HOSTWR);
  assign host_we                 = (state_r == ST_HOSTWR) && host_wr_ready;
  assign host_rgo                = (state_r == ST_HOSTRD) && !host_rd_ready;
  assign host_re                 = (state_r == ST_HOSTRD) && host_rd_ready;
  assign rd_valid                = (state_r == ST_RDRAIN);
  assign tx_done                 = done_s ? grant_r : '0;
  assign grant                   = grant_r;
  assign host_addr               = host_addr_r;
  assign host_data_bus_write_out = line_r;
  assign rd_data                 = line_r[WORD_SIZE*int'(idx_s) +: WORD_SIZE];

  // Main sequencer: arbitration, line fill, host handshakes and read drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_STARTUP;
      grant_r     <= '0;
      gidx_r      <= '0;
      ptr_r       <= '0;
      is_wr_r     <= 1'b0;
      host_addr_r <= '0;
      line_r      <= '0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        ST_STARTUP: begin
          if (host_init) begin
            state_r <= ST_READY;
          end
        end
        ST_READY: begin
          if (arb_found_s) begin
            grant_r     <= arb_gnt_s;
            gidx_r      <= arb_idx_s;
            is_wr_r     <= (sel_op_s == OP_WRITE);
            host_addr_r <= sel_addr_s & LINE_MASK;
            cnt_r       <= '0;
            state_r     <= (sel_op_s == OP_WRITE) ? ST_WFILL : ST_HOSTRD;
          end
        end
        ST_WFILL: begin
          // Newest word enters at the top so word 0 ends up in the low bits.
          line_r <= {sel_wdata_s, line_r[CL_SIZE_WIDTH-1:WORD_SIZE]};
          cnt_r  <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_HOSTWR;
          end
        end
        ST_HOSTWR: begin
          if (host_wr_ready) begin
            grant_r <= '0;
            ptr_r   <= next_ptr_s;
            state_r <= ST_READY;
          end
        end
        ST_HOSTRD: begin
          if (host_rd_ready) begin
            line_r  <= host_data_bus_read_in;
            cnt_r   <= '0;
            state_r <= ST_RDRAIN;
          end
        end
        ST_RDRAIN: begin
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            grant_r <= '0;
            ptr_r   <= next_ptr_s;
            state_r <= ST_READY;
          end
        end
        default: begin
          state_r <= ST_STARTUP;
          grant_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Self-checking bench for mem_ctrl_arb with a line-level reference model.
module tb_mem_ctrl_arb;

  localparam int WS = 32;
  localparam int CL = 512;
  localparam int AW = 64;
  localparam int NC = 2;
  localparam int FC = CL / WS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            host_init = 1'b0;
  logic            host_rd_ready = 1'b0;
  logic            host_wr_ready = 1'b0;
  logic [CL-1:0]   host_data_bus_read_in = '0;
  logic [CL-1:0]   host_data_bus_write_out;
  logic [AW-1:0]   host_addr;
  logic            host_re, host_we, host_rgo, host_wgo;
  logic [AW-1:0]   address_offset = '0;
  logic [2*NC-1:0] req_op = '0;
  logic [AW*NC-1:0] req_addr = '0;
  logic [WS*NC-1:0] req_wdata = '0;
  logic [NC-1:0]   grant, tx_done;
  logic [WS-1:0]   rd_data;
  logic            rd_valid, ready;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic [1:0]    op_tab[NC];
  logic [AW-1:0] addr_tab[NC];

  mem_ctrl_arb dut (
    .clk(clk), .rst(rst), .host_init(host_init),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .host_data_bus_read_in(host_data_bus_read_in),
    .host_data_bus_write_out(host_data_bus_write_out),
    .host_addr(host_addr), .host_re(host_re), .host_we(host_we),
    .host_rgo(host_rgo), .host_wgo(host_wgo),
    .address_offset(address_offset), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .rd_data(rd_data),
    .rd_valid(rd_valid), .tx_done(tx_done), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_req();
    for (int c = 0; c < NC; c++) begin
      req_op[2*c +: 2]    = op_tab[c];
      req_addr[AW*c +: AW] = addr_tab[c];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (model_ptr + k) % NC;
      if (op_tab[c] == 2'b01 || op_tab[c] == 2'b11) return c;
    end
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_strobes"}, {host_re, host_we, host_rgo, host_wgo, rd_valid}, '0);
    chk({tag, "_txdone"}, tx_done, '0);
  endtask

  task automatic init_pulse();
    host_init = 1'b1;
    step();
    host_init = 1'b0;
    chk("init_ready", ready, 1'b1);
  endtask

  // Serve one transaction expected from the model; caller is in a READY cycle.
  task automatic serve(input bit keep, input bit fixed_words, input int rd_delay,
                       input int wr_delay, input int abort_word, output int waited);
    int c, start;
    logic [AW-1:0] sum, ea;
    logic [NC-1:0] eg;
    logic [CL-1:0] line;
    logic [WS-1:0] wd;
    c = pick();
    eg = '0;
    if (c >= 0) eg[c] = 1'b1;
    sum = (c >= 0) ? addr_tab[c] + address_offset : '0;
    ea  = sum & ~64'h3F;
    waited = 0;
    while (grant === '0 && waited < 20) begin
      step();
      waited++;
    end
    chk("grant", grant, eg);
    if (c < 0) return;
    chk("host_addr", host_addr, ea);
    // Scramble the granted channel's request; it must be ignored until done.
    req_addr[AW*c +: AW] = {$urandom, $urandom};
    req_op[2*c +: 2]     = 2'b10;
    if (op_tab[c] == 2'b11) begin
      line = '0;
      for (int k = 0; k < FC; k++) begin
        wd = fixed_words ? 32'hA0 + 32'(k) : $urandom;
        line[WS*k +: WS] = wd;
        req_wdata = {$urandom, $urandom};
        req_wdata[WS*c +: WS] = wd;
        chk("wfill_grant", grant, eg);
        chk("wfill_wgo", host_wgo, 1'b0);
        step();
      end
      req_wdata = {$urandom, $urandom};
      chk("wr_wgo", host_wgo, 1'b1);
      chk("wr_line", host_data_bus_write_out, line);
      chk("wr_addr", host_addr, ea);
      for (int d = 0; d < wr_delay; d++) begin
        chk("wr_we_early", host_we, 1'b0);
        chk("wr_done_early", tx_done, '0);
        step();
      end
      host_wr_ready = 1'b1;
      #1;
      chk("wr_we", host_we, 1'b1);
      chk("wr_done", tx_done, eg);
      chk("wr_grant_held", grant, eg);
      step();
      host_wr_ready = 1'b0;
      chk("wr_we_after", host_we, 1'b0);
    end else begin
      for (int d = 0; d < rd_delay; d++) begin
        chk("rd_rgo", host_rgo, 1'b1);
        chk("rd_re_early", host_re, 1'b0);
        step();
      end
      for (int k = 0; k < FC; k++) line[WS*k +: WS] = $urandom;
      host_data_bus_read_in = line;
      host_rd_ready = 1'b1;
      #1;
      chk("rd_re", host_re, 1'b1);
      chk("rd_rgo_off", host_rgo, 1'b0);
      step();
      host_rd_ready = 1'b0;
      for (int k = 0; k < FC; k++) host_data_bus_read_in[WS*k +: WS] = $urandom;
`ifdef MEM_CTRL_CRIT_WORD_FIRST_EN
      start = int'(sum[5:2]);
`else
      start = 0;
`endif
      for (int k = 0; k < FC; k++) begin
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_re_once", host_re, 1'b0);
        chk("rd_data", rd_data, line[WS*((start + k) % FC) +: WS]);
        chk("rd_done", tx_done, (k == FC - 1) ? eg : '0);
        chk("rd_grant_held", grant, eg);
        if (k == abort_word) begin
          rst = 1'b1;
          #1;
          check_idle_outputs("abort");
          chk("abort_addr", host_addr, '0);
          chk("abort_line", host_data_bus_write_out, '0);
          chk("abort_rdata", rd_data, '0);
          model_ptr = 0;
          return;
        end
        step();
      end
    end
    model_ptr = (c + 1) % NC;
    chk("back_ready", ready, 1'b1);
    chk("back_grant", grant, '0);
    chk("back_valid", rd_valid, 1'b0);
    if (!keep) begin
      for (int i = 0; i < NC; i++) op_tab[i] = 2'b00;
    end
    apply_req();
  endtask

  initial begin
    int w;
    for (int i = 0; i < NC; i++) begin
      op_tab[i] = 2'b00;
      addr_tab[i] = '0;
    end
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_addr", host_addr, '0);
    chk("reset_line", host_data_bus_write_out, '0);
    rst = 1'b0;

    // STARTUP ignores requests and host handshakes until host_init.
    op_tab[0] = 2'b01;
    addr_tab[0] = 64'h3000;
    apply_req();
    host_rd_ready = 1'b1;
    host_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle_outputs("startup");
    end
    host_rd_ready = 1'b0;
    host_wr_ready = 1'b0;
    init_pulse();
    serve(1'b0, 1'b0, 2, 0, -1, w);

    // Directed write ch0.
    address_offset = 64'h40;
    op_tab[0] = 2'b11;
    addr_tab[0] = 64'h1000;
    apply_req();
    serve(1'b0, 1'b1, 0, 0, -1, w);

    // Read ch1 with host_rd_ready delayed 5 cycles.
    address_offset = '0;
    op_tab[1] = 2'b01;
    addr_tab[1] = 64'h0000_0000_0000_5ABC;
    apply_req();
    serve(1'b0, 1'b0, 5, 0, -1, w);

    // Both channels reading continuously: alternation, one idle cycle between.
    op_tab[0] = 2'b01;
    op_tab[1] = 2'b01;
    addr_tab[0] = 64'h7000;
    addr_tab[1] = 64'h8040;
    apply_req();
    for (int t = 0; t < 4; t++) begin
      serve((t != 3), 1'b0, t % 2, 0, -1, w);
      if (t > 0) chk("b2b_gap", w, 1);
    end

    // Randomised mixed traffic.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NC; i++) begin
        op_tab[i] = 2'($urandom_range(0, 3));
        addr_tab[i] = {$urandom, $urandom};
      end
      if (pick() < 0) op_tab[$urandom_range(0, NC - 1)] = 2'b01;
      address_offset = {$urandom, $urandom};
      apply_req();
      serve(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), -1, w);
    end

    // Critical-word address case.
    address_offset = '0;
    op_tab[0] = 2'b01;
    addr_tab[0] = 64'h2024;
    apply_req();
    serve(1'b0, 1'b0, 1, 0, -1, w);

    // Reset during drain at word 7, then recovery.
    op_tab[1] = 2'b01;
    addr_tab[1] = 64'h9000;
    apply_req();
    serve(1'b0, 1'b0, 1, 0, 7, w);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle_outputs("post_reset");
    end
    op_tab[0] = 2'b01;
    addr_tab[0] = 64'h4400;
    apply_req();
    init_pulse();
    serve(1'b0, 1'b0, 0, 0, -1, w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
